// File: rtl/fetch_sequencer.sv
// fetch_sequencer: walks a code segment, decodes variable-length instructions
// (cmd + argc args) and hands them to an executor over a valid/ready handshake.
// A cmd of 0 halts the walk; an out-of-range pc or an illegal argc latches a
// sticky fault that only rst can clear.
module fetch_sequencer #(
  parameter int WORD_SIZE_ = 32,
  parameter int ADDR_SIZE_ = 32,
  parameter int WORDS_NUM_ = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [ADDR_SIZE_-1:0]   mem_addr,
  input  logic [3*WORD_SIZE_-1:0] mem_value,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [WORD_SIZE_-1:0]   instr_cmd,
  output logic [WORD_SIZE_-1:0]   instr_arg1,
  output logic [WORD_SIZE_-1:0]   instr_arg2,
  output logic [ADDR_SIZE_-1:0]   instr_pc,
  input  logic                    jump_valid,
  input  logic [ADDR_SIZE_-1:0]   jump_addr,
  output logic                    halted,
  output logic                    fault
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    PRESENT = 3'd2,
    HALT    = 3'd3,
    FAULT   = 3'd4
  } state_t;

  // Highest pc whose three-word window still lies inside the segment.
  localparam logic [ADDR_SIZE_-1:0] LAST_PC = ADDR_SIZE_'(WORDS_NUM_ - 3);

  state_t                  state_reg;
  logic [ADDR_SIZE_-1:0]   pc_reg;
  logic                    instr_valid_reg;
  logic [WORD_SIZE_-1:0]   instr_cmd_reg;
  logic [WORD_SIZE_-1:0]   instr_arg1_reg;
  logic [WORD_SIZE_-1:0]   instr_arg2_reg;
  logic [ADDR_SIZE_-1:0]   instr_pc_reg;
  logic                    halted_reg;
  logic                    fault_reg;

  // Word view of the memory window: 0 = cmd, 1 = arg1, 2 = arg2.
  logic [WORD_SIZE_-1:0]   mem_word [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_word
      assign mem_word[gi] = mem_value[gi*WORD_SIZE_ +: WORD_SIZE_];
    end
  endgenerate

  logic [1:0]              fetch_argc;
  logic                    fetch_out_of_range;
  logic                    fetch_is_halt;
  logic                    handshake;
  logic [ADDR_SIZE_-1:0]   pc_seq_next;

  // Decode of the word currently addressed by pc, and the sequential successor
  // of the presented instruction (length = argc + 1, wraps at 2^ADDR_SIZE_).
  always_comb begin
    fetch_argc         = mem_word[0][1:0];
    fetch_out_of_range = (pc_reg > LAST_PC);
    fetch_is_halt      = (mem_word[0] == '0);
    handshake          = instr_valid_reg && instr_ready;
    pc_seq_next        = pc_reg + ADDR_SIZE_'(instr_cmd_reg[1:0]) + ADDR_SIZE_'(1);
  end

  // Sequencer FSM; every output is a register so nothing downstream sees decode glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      pc_reg          <= '0;
      instr_valid_reg <= 1'b0;
      instr_cmd_reg   <= '0;
      instr_arg1_reg  <= '0;
      instr_arg2_reg  <= '0;
      instr_pc_reg    <= '0;
      halted_reg      <= 1'b0;
      fault_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            pc_reg    <= '0;
            state_reg <= FETCH;
          end
        end

        FETCH: begin
          // Range is checked first so a bad pc never interprets garbage data.
          if (fetch_out_of_range) begin
            fault_reg <= 1'b1;
            state_reg <= FAULT;
          end else if (fetch_is_halt) begin
            halted_reg <= 1'b1;
            state_reg  <= HALT;
          end else if (fetch_argc == 2'd3) begin
            fault_reg <= 1'b1;
            state_reg <= FAULT;
          end else begin
            instr_cmd_reg   <= mem_word[0];
            instr_arg1_reg  <= mem_word[1];
            instr_arg2_reg  <= mem_word[2];
            instr_pc_reg    <= pc_reg;
            instr_valid_reg <= 1'b1;
            state_reg       <= PRESENT;
          end
        end

        PRESENT: begin
          // Outputs hold until the executor takes the instruction; jump
          // requests are only meaningful on that same cycle.
          if (handshake) begin
            instr_valid_reg <= 1'b0;
            pc_reg          <= jump_valid ? jump_addr : pc_seq_next;
            state_reg       <= FETCH;
          end
        end

        HALT: begin
          // pc keeps pointing at the halt word until execution is restarted.
          if (start) begin
            pc_reg     <= '0;
            halted_reg <= 1'b0;
            state_reg  <= FETCH;
          end
        end

        FAULT: begin
          state_reg <= FAULT;
        end

        default: begin
          instr_valid_reg <= 1'b0;
          fault_reg       <= 1'b1;
          state_reg       <= FAULT;
        end
      endcase
    end
  end

  assign mem_addr    = pc_reg;
  assign instr_valid = instr_valid_reg;
  assign instr_cmd   = instr_cmd_reg;
  assign instr_arg1  = instr_arg1_reg;
  assign instr_arg2  = instr_arg2_reg;
  assign instr_pc    = instr_pc_reg;
  assign halted      = halted_reg;
  assign fault       = fault_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios against a small behavioural code
// segment; every expected value below is worked out by hand from the program.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  localparam int W = 32;
  localparam int A = 32;
  localparam int N = 64;

  logic           clk;
  logic           rst;
  logic           start;
  logic [A-1:0]   mem_addr;
  logic [3*W-1:0] mem_value;
  logic           instr_valid;
  logic           instr_ready;
  logic [W-1:0]   instr_cmd;
  logic [W-1:0]   instr_arg1;
  logic [W-1:0]   instr_arg2;
  logic [A-1:0]   instr_pc;
  logic           jump_valid;
  logic [A-1:0]   jump_addr;
  logic           halted;
  logic           fault;

  logic [W-1:0]   mem [N];

  int checks;
  int failures;

  fetch_sequencer #(.WORD_SIZE_(W), .ADDR_SIZE_(A), .WORDS_NUM_(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_addr   (mem_addr),
    .mem_value  (mem_value),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_cmd  (instr_cmd),
    .instr_arg1 (instr_arg1),
    .instr_arg2 (instr_arg2),
    .instr_pc   (instr_pc),
    .jump_valid (jump_valid),
    .jump_addr  (jump_addr),
    .halted     (halted),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rd(input logic [A-1:0] a);
    if (a < A'(N)) return mem[a[5:0]];
    return '0;
  endfunction

  // Combinational code segment: three consecutive words starting at mem_addr.
  always_comb mem_value = {rd(mem_addr + A'(2)), rd(mem_addr + A'(1)), rd(mem_addr)};

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end else begin
      $display("ok   %s: 0x%0h at %0t", tag, observed, $time);
    end
  endtask

  // Advance one clock and settle 1ns past the edge before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle_outputs(input string tag);
    check({tag, ".valid"},  64'(instr_valid), 64'd0);
    check({tag, ".cmd"},    64'(instr_cmd),   64'd0);
    check({tag, ".ipc"},    64'(instr_pc),    64'd0);
    check({tag, ".halted"}, 64'(halted),      64'd0);
    check({tag, ".fault"},  64'(fault),       64'd0);
    check({tag, ".addr"},   64'(mem_addr),    64'd0);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #2;
    expect_idle_outputs(tag);
    rst = 1'b0;
    step();
  endtask

  task automatic expect_instr(input string tag, input logic [W-1:0] cmd,
                              input logic [W-1:0] a1, input logic [W-1:0] a2,
                              input logic [A-1:0] pc);
    check({tag, ".valid"}, 64'(instr_valid), 64'd1);
    check({tag, ".cmd"},   64'(instr_cmd),   64'(cmd));
    check({tag, ".arg1"},  64'(instr_arg1),  64'(a1));
    check({tag, ".arg2"},  64'(instr_arg2),  64'(a2));
    check({tag, ".ipc"},   64'(instr_pc),    64'(pc));
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    start       = 1'b0;
    instr_ready = 1'b0;
    jump_valid  = 1'b0;
    jump_addr   = '0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    mem[0] = 32'h102; mem[1] = 32'd5; mem[2] = 32'd7; mem[3] = 32'h200; mem[4] = 32'h0;

    // Reset state
    repeat (2) step();
    expect_idle_outputs("reset");
    rst = 1'b0;
    step();
    check("idle_no_start.valid", 64'(instr_valid), 64'd0);

    // Sequential run, ready held high: 2-cycle throughput, then HALT
    start = 1'b1; instr_ready = 1'b1;
    step();
    start = 1'b0;
    check("seq.fetch0.valid", 64'(instr_valid), 64'd0);
    check("seq.fetch0.addr",  64'(mem_addr),    64'd0);
    step();
    expect_instr("seq.i0", 32'h102, 32'd5, 32'd7, 32'd0);
    step();
    check("seq.fetch3.valid", 64'(instr_valid), 64'd0);
    check("seq.fetch3.addr",  64'(mem_addr),    64'd3);
    step();
    expect_instr("seq.i1", 32'h200, 32'd0, 32'd0, 32'd3);
    step();
    check("seq.fetch4.addr", 64'(mem_addr), 64'd4);
    step();
    check("seq.halt.halted", 64'(halted),      64'd1);
    check("seq.halt.valid",  64'(instr_valid), 64'd0);
    check("seq.halt.addr",   64'(mem_addr),    64'd4);
    step();
    check("seq.halt_hold.halted", 64'(halted), 64'd1);

    // Backpressure: outputs frozen while ready is low, one handshake on release
    start = 1'b1; instr_ready = 1'b0;
    step();
    start = 1'b0;
    check("bp.restart.halted", 64'(halted),   64'd0);
    check("bp.restart.addr",   64'(mem_addr), 64'd0);
    step();
    expect_instr("bp.first", 32'h102, 32'd5, 32'd7, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      expect_instr($sformatf("bp.stall%0d", c), 32'h102, 32'd5, 32'd7, 32'd0);
      check($sformatf("bp.stall%0d.addr", c), 64'(mem_addr), 64'd0);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("bp.release.valid", 64'(instr_valid), 64'd0);
    check("bp.release.addr",  64'(mem_addr),    64'd3);
    step();
    expect_instr("bp.next", 32'h200, 32'd0, 32'd0, 32'd3);
    instr_ready = 1'b1;
    repeat (2) step();
    check("bp.end.halted", 64'(halted), 64'd1);

    // Jump: ignored without handshake, taken on handshake
    mem[0] = 32'h101; mem[1] = 32'd5; mem[2] = 32'h0;
    start = 1'b1; instr_ready = 1'b0;
    step();
    start = 1'b0;
    step();
    expect_instr("jmp.i0", 32'h101, 32'd5, 32'h0, 32'd0);
    jump_valid = 1'b1; jump_addr = 32'd7;
    step();
    check("jmp.nohs.valid", 64'(instr_valid), 64'd1);
    check("jmp.nohs.addr",  64'(mem_addr),    64'd0);
    instr_ready = 1'b1; jump_addr = 32'd3;
    step();
    jump_valid = 1'b0;
    check("jmp.taken.addr", 64'(mem_addr), 64'd3);
    step();
    expect_instr("jmp.target", 32'h200, 32'd0, 32'd0, 32'd3);
    repeat (2) step();
    check("jmp.end.halted", 64'(halted), 64'd1);

    // Bounds: pc 61 is the last legal window, pc 62 faults stickily
    mem[61] = 32'h200;
    start = 1'b1; instr_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    jump_valid = 1'b1; jump_addr = 32'd61;
    step();
    jump_valid = 1'b0;
    check("bnd.fetch61.addr", 64'(mem_addr), 64'd61);
    step();
    expect_instr("bnd.i61", 32'h200, 32'd0, 32'd0, 32'd61);
    jump_valid = 1'b1; jump_addr = 32'd62;
    step();
    jump_valid = 1'b0;
    check("bnd.fetch62.addr",  64'(mem_addr), 64'd62);
    check("bnd.fetch62.fault", 64'(fault),    64'd0);
    step();
    check("bnd.fault",       64'(fault),       64'd1);
    check("bnd.fault.valid", 64'(instr_valid), 64'd0);
    start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("bnd.sticky%0d.fault", c), 64'(fault),       64'd1);
      check($sformatf("bnd.sticky%0d.valid", c), 64'(instr_valid), 64'd0);
      check($sformatf("bnd.sticky%0d.addr", c),  64'(mem_addr),    64'd62);
    end
    start = 1'b0;
    apply_reset("bnd.rst");

    // Illegal argc faults one cycle after FETCH
    mem[0] = 32'h003;
    start = 1'b1;
    step();
    start = 1'b0;
    check("argc.fetch.fault", 64'(fault), 64'd0);
    step();
    check("argc.fault",       64'(fault),       64'd1);
    check("argc.fault.valid", 64'(instr_valid), 64'd0);
    apply_reset("argc.rst");

    // Asynchronous reset mid-PRESENT, then restart from pc 0
    mem[0] = 32'h102; mem[1] = 32'd5; mem[2] = 32'd7;
    start = 1'b1; instr_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    instr_ready = 1'b0;
    step();
    expect_instr("arst.pre", 32'h200, 32'd0, 32'd0, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    expect_idle_outputs("arst.async");
    rst = 1'b0;
    step();
    check("arst.idle.valid", 64'(instr_valid), 64'd0);
    check("arst.idle.addr",  64'(mem_addr),    64'd0);
    step();
    check("arst.idle2.valid", 64'(instr_valid), 64'd0);
    start = 1'b1; instr_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    expect_instr("arst.refetch", 32'h102, 32'd5, 32'd7, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter WORD_SIZE_, default 32: code word width in bits.
REQ-002 Parameter ADDR_SIZE_, default 32: code address width.
REQ-003 Parameter WORDS_NUM_, default 64: number of words in the attached code segment.
REQ-004 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port start  input  1  begin or restart execution at address 0.
REQ-007 Port mem_addr  output  ADDR_SIZE_  read address to the code segment.
REQ-008 Port mem_value  input  3*WORD_SIZE_  code segment data: [W-1:0]=cmd, [2W-1:W]=arg1, [3W-1:2W]=arg2; combinational, valid in the cycle mem_addr is driven.
REQ-009 Port instr_valid  output  1  instruction outputs hold a valid instruction.
REQ-010 Port instr_ready  input  1  executor accepts the instruction.
REQ-011 Port instr_cmd / instr_arg1 / instr_arg2  output  WORD_SIZE_ each  latched instruction words.
REQ-012 Port instr_pc  output  ADDR_SIZE_  address of the presented instruction.
REQ-013 Port jump_valid  input  1  redirect request; sampled only on the handshake cycle.
REQ-014 Port jump_addr  input  ADDR_SIZE_  redirect target.
REQ-015 Port halted / fault  output  1 each  status flags.

Function
REQ-016 The FSM SHALL have exactly five states: IDLE, FETCH, PRESENT, HALT, FAULT.
REQ-017 Instruction length SHALL be argc+1 words, where argc = cmd[1:0]; argc=3 is illegal.
REQ-018 A cmd word equal to 0 SHALL be HALT and SHALL never be presented to the executor.
REQ-019 In IDLE, start=1 SHALL set pc=0 and move to FETCH; in all other states, start SHALL be ignored except in HALT.
REQ-020 In FETCH, mem_addr SHALL equal pc and the FSM SHALL check, in priority order:
- pc > WORDS_NUM_-3 (unsigned): go to FAULT.
- cmd == 0: go to HALT.
- argc == 3: go to FAULT.
- otherwise: latch cmd/arg1/arg2/pc into the output registers and go to PRESENT.
REQ-021 In PRESENT, instr_valid SHALL be 1; all instr_* outputs SHALL stay stable until instr_valid && instr_ready.
REQ-022 On handshake, if jump_valid=1 then pc SHALL become jump_addr; otherwise pc SHALL become pc+len, modulo 2^ADDR_SIZE_. The FSM SHALL then return to FETCH.
REQ-023 jump_valid outside a handshake cycle SHALL have no effect.
REQ-024 Latency: start sampled in cycle N -> FETCH in N+1 -> instr_valid=1 in N+2. With instr_ready held at 1, throughput SHALL be one instruction per 2 cycles.
REQ-025 In HALT, halted SHALL be 1 and pc SHALL hold the HALT word address; start=1 SHALL set pc=0, clear halted and go to FETCH.
REQ-026 FAULT SHALL be sticky: fault=1, instr_valid=0, and only rst exits it.
REQ-027 mem_addr SHALL be driven with pc in every state.
REQ-028 instr_valid SHALL be 0 in every state except PRESENT.

Reset
REQ-029 rst=1 SHALL, immediately and independently of clk, force state=IDLE and pc=0, and clear instr_valid, instr_cmd, instr_arg1, instr_arg2, instr_pc, halted and fault.
REQ-030 Reset asserted in any state, including mid-PRESENT or in FAULT, SHALL discard the pending instruction. No handshake SHALL complete in that cycle.
REQ-031 After rst deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-032 Sequential run: MEM[0]=0x102, MEM[1]=5, MEM[2]=7, MEM[3]=0x200, MEM[4]=0; start pulse with ready=1 -> (cmd 0x102, args 5/7, pc 0) at N+2, then (cmd 0x200, pc 3) at N+4, then halted=1 with instr_valid=0.
REQ-033 Backpressure: hold instr_ready=0 for 3 cycles during PRESENT -> outputs and pc unchanged, exactly one handshake when ready rises.
REQ-034 Jump: handshake on pc 0 with jump_valid=1, jump_addr=3 -> next presented instr_pc=3, cmd 0x200.
REQ-035 Bounds: jump_addr=62 with WORDS_NUM_=64 -> fault=1, instr_valid never asserted, start ignored until rst.
REQ-036 Illegal argc: MEM[0]=0x003 -> fault=1 one cycle after FETCH.
REQ-037 Async reset: pulse rst between clock edges during PRESENT -> instr_valid=0 before the next edge, state IDLE; a subsequent start refetches from pc 0.
